// File: rtl/imm_operand_encoder.sv
// rtl/imm_operand_encoder.sv - searches the 12-bit shift_operand field that reproduces a 32-bit constant
module imm_operand_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_store,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] shift_operand
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [3:0]  r_q, r_d;
    logic        valid_q, valid_d;
    logic [11:0] so_q, so_d;

    // A load/store offset fits when bits 31..11 are a pure sign extension of bit 11.
    logic ls_fits;
    assign ls_fits = (&value[31:11]) | ~(|value[31:11]);

    // Next-state logic: accept in IDLE/DONE, walk rotations in SEARCH, smallest rotation wins.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        r_d     = r_q;
        valid_d = valid_q;
        so_d    = so_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    if (load_store) begin
                        state_d = S_DONE;
                        valid_d = ls_fits;
                        so_d    = ls_fits ? value[11:0] : 12'h000;
                    end else begin
                        state_d = S_SEARCH;
                        w_d     = value;
                        r_d     = 4'd0;
                    end
                end
            end
            S_SEARCH: begin
                if (w_q[31:8] == 24'h000000) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    so_d    = {r_q, w_q[7:0]};
                end else if (r_q == 4'd15) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    so_d    = 12'h000;
                end else begin
                    // Rotating w left by 2 undoes one step of the decoder's rotate-right.
                    w_d = {w_q[29:0], w_q[31:30]};
                    r_d = r_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts any search without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= 32'h0;
            r_q     <= 4'd0;
            valid_q <= 1'b0;
            so_q    <= 12'h000;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            r_q     <= r_d;
            valid_q <= valid_d;
            so_q    <= so_d;
        end
    end

    assign busy          = (state_q == S_SEARCH);
    assign done          = (state_q == S_DONE);
    assign valid         = valid_q;
    assign shift_operand = so_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// tb/tb_imm_operand_encoder.sv - self-checking bench for imm_operand_encoder
module tb_imm_operand_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        load_store;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic [11:0] shift_operand;

    int checks = 0;
    int errors = 0;

    logic        prev_valid;
    logic [11:0] prev_so;

    imm_operand_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .load_store    (load_store),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .valid         (valid),
        .shift_operand (shift_operand)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        logic [31:0] l;
        logic [31:0] h;
        l = x >> s;
        h = (s == 0) ? 32'h0 : (x << (32 - s));
        return l | h;
    endfunction

    // Reference: load/store fits a signed 12-bit range; immediate takes the smallest even rotation.
    task automatic model(input bit ls, input logic [31:0] v,
                         output bit m_valid, output logic [11:0] m_so, output int m_lat);
        m_valid = 1'b0;
        m_so    = 12'h000;
        if (ls) begin
            m_lat = 1;
            if ($signed(v) >= -2048 && $signed(v) <= 2047) begin
                m_valid = 1'b1;
                m_so    = v[11:0];
            end
        end else begin
            m_lat = 17;
            for (int rot = 15; rot >= 0; rot--) begin
                logic [31:0] x;
                x = ror32(v, (32 - 2 * rot) % 32);
                if (x < 32'd256) begin
                    m_valid = 1'b1;
                    m_so    = {rot[3:0], x[7:0]};
                    m_lat   = rot + 2;
                end
            end
        end
    endtask

    // Launch one request (accepted on the next edge), wait for done, check against the model.
    task automatic run_one(input bit ls, input logic [31:0] v, input string tag,
                           output int lat, output logic o_valid, output logic [11:0] o_so);
        bit          m_valid;
        logic [11:0] m_so;
        int          m_lat;
        bit          hold_ok;
        bit          overlap;
        logic [31:0] dec;
        model(ls, v, m_valid, m_so, m_lat);
        start      = 1'b1;
        load_store = ls;
        value      = v;
        tick();
        start      = 1'b0;
        value      = $urandom;
        load_store = $urandom_range(0, 1);
        lat     = 1;
        hold_ok = 1'b1;
        overlap = 1'b0;
        while (done !== 1'b1 && lat <= 20) begin
            if (busy !== 1'b1 || valid !== prev_valid || shift_operand !== prev_so) hold_ok = 1'b0;
            tick();
            lat++;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        o_valid = valid;
        o_so    = shift_operand;
        check({tag, " latency"}, lat, m_lat);
        check({tag, " valid"}, valid, m_valid);
        check({tag, " shift_operand"}, shift_operand, m_so);
        check({tag, " hold/busy during search"}, hold_ok, 1'b1);
        check({tag, " busy with done"}, overlap, 1'b0);
        if (valid === 1'b1) begin
            if (ls) dec = {{20{shift_operand[11]}}, shift_operand};
            else    dec = ror32({24'h0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
            check({tag, " decode"}, dec, v);
        end else begin
            check({tag, " zero when invalid"}, shift_operand, 12'h000);
        end
        prev_valid = valid;
        prev_so    = shift_operand;
    endtask

    initial begin
        int          lat;
        logic        ov;
        logic [11:0] os;
        bit          saw_done;

        rst        = 1'b1;
        start      = 1'b0;
        load_store = 1'b0;
        value      = 32'h0;
        prev_valid = 1'b0;
        prev_so    = 12'h000;
        tick();
        tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset valid", valid, 1'b0);
        check("reset shift_operand", shift_operand, 12'h000);
        rst = 1'b0;
        tick();

        // Directed immediate cases.
        run_one(1'b0, 32'h0000002A, "imm 0x2A", lat, ov, os);
        check("imm 0x2A const", {lat[7:0], 3'b0, ov, os}, {8'd2, 4'h1, 12'h02A});
        tick();
        run_one(1'b0, 32'hFF000000, "imm 0xFF000000", lat, ov, os);
        check("imm 0xFF000000 const", {lat[7:0], 3'b0, ov, os}, {8'd6, 4'h1, 12'h4FF});
        tick();
        run_one(1'b0, 32'hF000000F, "imm 0xF000000F", lat, ov, os);
        check("imm 0xF000000F const", {lat[7:0], 3'b0, ov, os}, {8'd4, 4'h1, 12'h2FF});
        run_one(1'b0, 32'h000003FC, "imm 0x3FC", lat, ov, os);
        check("imm 0x3FC const", {lat[7:0], 3'b0, ov, os}, {8'd17, 4'h1, 12'hFFF});
        run_one(1'b0, 32'h00000101, "imm 0x101", lat, ov, os);
        check("imm 0x101 const", {lat[7:0], 3'b0, ov, os}, {8'd17, 4'h0, 12'h000});
        run_one(1'b0, 32'h00000102, "imm 0x102", lat, ov, os);
        check("imm 0x102 const", {lat[7:0], 3'b0, ov, os}, {8'd17, 4'h0, 12'h000});
        run_one(1'b0, 32'h00000000, "imm zero", lat, ov, os);
        check("imm zero const", {lat[7:0], 3'b0, ov, os}, {8'd2, 4'h1, 12'h000});

        // Directed load/store cases.
        run_one(1'b1, 32'hFFFFF800, "ls 0xFFFFF800", lat, ov, os);
        check("ls 0xFFFFF800 const", {lat[7:0], 3'b0, ov, os}, {8'd1, 4'h1, 12'h800});
        run_one(1'b1, 32'h00000800, "ls 0x800", lat, ov, os);
        check("ls 0x800 const", {lat[7:0], 3'b0, ov, os}, {8'd1, 4'h0, 12'h000});
        run_one(1'b1, 32'h000007FF, "ls 0x7FF", lat, ov, os);
        check("ls 0x7FF const", {lat[7:0], 3'b0, ov, os}, {8'd1, 4'h1, 12'h7FF});

        // Back-to-back from DONE: launched above without an idle cycle; now check return to IDLE.
        tick();
        check("idle after done", {busy, done}, 2'b00);

        // Start pulsed during SEARCH is ignored and not queued.
        start = 1'b1; load_store = 1'b0; value = 32'hFF000000;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; value = 32'h0000002A;
        tick();
        start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat <= 20) begin
            tick();
            lat++;
        end
        check("start-in-search latency", lat, 6);
        check("start-in-search result", {3'b0, valid, shift_operand}, {4'h1, 12'h4FF});
        tick();
        check("start-in-search not queued", {busy, done}, 2'b00);
        prev_valid = valid;
        prev_so    = shift_operand;

        // Reset in cycle 5 of a search.
        start = 1'b1; load_store = 1'b0; value = 32'h00000101;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid outputs", {busy, done, valid, shift_operand}, 15'h0);
        saw_done = 1'b0;
        repeat (20) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("rst mid no done, idle", saw_done, 1'b0);
        prev_valid = 1'b0;
        prev_so    = 12'h000;

        // Random sweep, back-to-back, mixing encodable, arbitrary and load/store values.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] v;
            bit          ls;
            int          sel;
            sel = $urandom_range(0, 3);
            ls  = (sel == 3);
            case (sel)
                0:       v = ror32({24'h0, 8'($urandom)}, 2 * $urandom_range(0, 15));
                1:       v = $urandom;
                2:       v = 32'h0000_0001 << $urandom_range(0, 31);
                default: v = ($urandom_range(0, 1) == 1) ? {{20{1'b1}}, 12'($urandom)} : $urandom;
            endcase
            run_one(ls, v, "sweep", lat, ov, os);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
